// File: rtl/i2s_define.sv
// Shared I2S encodings plus small decode helpers used by the clock generator.
package i2s_define;

   localparam logic       I2S_CHL_16_BITS = 1'b0;
   localparam logic       I2S_CHL_32_BITS = 1'b1;

   localparam logic [1:0] I2S_FMT_I2S     = 2'd0;
   localparam logic [1:0] I2S_FMT_MSB     = 2'd1;
   localparam logic [1:0] I2S_FMT_LSB     = 2'd2;

   function automatic logic [5:0] chl_len(input logic chl);
      logic [5:0] len;
      len = 6'd16;
      case (chl)
         I2S_CHL_32_BITS: len = 6'd32;
         I2S_CHL_16_BITS: len = 6'd16;
      endcase
      return len;
   endfunction

   // The reserved encoding behaves like MSB-justified.
   function automatic logic [1:0] fmt_norm(input logic [1:0] fmt);
      if (fmt == I2S_FMT_I2S || fmt == I2S_FMT_LSB) return fmt;
      return I2S_FMT_MSB;
   endfunction

   // Word select for a given bit position; I2S leads the channel boundary by one bit.
   function automatic logic ws_of(input logic [5:0] bit_cnt, input logic chl,
                                  input logic [1:0] fmt);
      logic [6:0] len;
      logic [6:0] b;
      len = {1'b0, chl_len(chl)};
      b   = {1'b0, bit_cnt};
      if (fmt == I2S_FMT_I2S) return (b >= len - 7'd1) && (b != (len << 1) - 7'd1);
      return b >= len;
   endfunction

endpackage

// File: rtl/dffr.sv
// Plain D flop bank with asynchronous active-low clear to zero.
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
   end

endmodule

// File: rtl/i2s_clkgen.sv
// I2S bit-clock / word-select generator; every output comes straight from a flop.
module i2s_clkgen
   import i2s_define::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 chl_i,
   input  logic [1:0]           fmt_i,
   input  logic                 wspol_i,
   output logic                 i2s_sck_o,
   output logic                 i2s_ws_o,
   output logic                 sck_fe_o,
   output logic                 frame_o,
   output logic                 busy_o
);

   logic                 en_q, en_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [5:0]           bit_q, bit_d, bit_last;
   logic [1:0]           fmt_q, fmt_d;
   logic                 chl_q, chl_d, wspol_q, wspol_d;
   logic                 sck_q, sck_d, ws_q, ws_d, wso_q, wso_d;
   logic                 fe_q, fe_d, frame_q, frame_d;
   logic                 tick, fall, wrap;

   assign bit_last = (chl_len(chl_q) << 1) - 6'd1;
   assign tick     = en_i && en_q && (cnt_q == div_q);
   assign fall     = tick && sck_q;
   assign wrap     = fall && (bit_q == bit_last);

   always_comb begin
      en_d    = en_i;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      fmt_d   = fmt_q;
      chl_d   = chl_q;
      wspol_d = wspol_q;
      sck_d   = sck_q;
      ws_d    = ws_q;
      wso_d   = wso_q;
      fe_d    = 1'b0;
      frame_d = 1'b0;
      if (!en_i) begin
         cnt_d = '0;
         sck_d = 1'b0;
         bit_d = '0;
         ws_d  = 1'b0;
         wso_d = 1'b0;
      end else if (!en_q) begin
         div_d   = div_i;
         chl_d   = chl_i;
         fmt_d   = fmt_norm(fmt_i);
         wspol_d = wspol_i;
         cnt_d   = '0;
         sck_d   = 1'b0;
         bit_d   = '0;
         ws_d    = 1'b0;
         wso_d   = wspol_i;
      end else begin
         cnt_d   = tick ? '0 : cnt_q + DIV_WIDTH'(1);
         sck_d   = sck_q ^ tick;
         fe_d    = fall;
         frame_d = wrap;
         if (fall) begin
            bit_d = wrap ? 6'd0 : bit_q + 6'd1;
            ws_d  = ws_of(bit_d, chl_q, fmt_q);
         end
         // Reload at the frame edge so a new divider starts with a fresh half-period.
         if (wrap) begin
            div_d   = div_i;
            chl_d   = chl_i;
            fmt_d   = fmt_norm(fmt_i);
            wspol_d = wspol_i;
         end
         wso_d = ws_d ^ wspol_d;
      end
   end

   dffr #(.W(8)) u_flag (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .d     ({en_d, sck_d, ws_d, wso_d, fe_d, frame_d, chl_d, wspol_d}),
      .q     ({en_q, sck_q, ws_q, wso_q, fe_q, frame_q, chl_q, wspol_q})
   );

   dffr #(.W(2)) u_fmt (.clk(clk_i), .rst_n(rst_n_i), .d(fmt_d), .q(fmt_q));
   dffr #(.W(6)) u_bit (.clk(clk_i), .rst_n(rst_n_i), .d(bit_d), .q(bit_q));
   dffr #(.W(DIV_WIDTH)) u_cnt (.clk(clk_i), .rst_n(rst_n_i), .d(cnt_d), .q(cnt_q));
   dffr #(.W(DIV_WIDTH)) u_div (.clk(clk_i), .rst_n(rst_n_i), .d(div_d), .q(div_q));

   assign i2s_sck_o = sck_q;
   assign i2s_ws_o  = wso_q;
   assign sck_fe_o  = fe_q;
   assign frame_o   = frame_q;
   assign busy_o    = en_q;

endmodule
